hex_digit_source: RTL

- Upstream feeder for the 7-segment decoder stage: it produces the 4-bit `hex_digit` value that the decoder consumes.
- Three active-low board pushbuttons (UP, DOWN, LOAD) are synchronised and debounced. Each debounced press is turned into a single-cycle event that edits a registered 4-bit value.
- LOAD copies the 4 slide switches into the value. UP and DOWN increment and decrement it, wrapping modulo 16.

---
 rtl/hex_digit_source.sv | 103 ++++++++++
 1 files changed

// File: rtl/hex_digit_source.sv
// Pushbutton front end for the 7-segment path: debounced UP/DOWN/LOAD
// keys edit a registered 4-bit digit, with a strobe per accepted edit.
module hex_digit_source #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_load_n,
  input  logic [3:0] sw,
  output logic [3:0] hex_digit,
  output logic       digit_strobe
);

  localparam int UP = 0;
  localparam int DN = 1;
  localparam int LD = 2;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0] key_raw;
  logic [2:0] key_meta;
  logic [2:0] key_s;
  logic [3:0] sw_meta;
  logic [3:0] sw_s;

  logic [2:0]       stable;
  logic [2:0]       press;
  logic [CNT_W-1:0] cnt     [3];
  logic [CNT_W-1:0] cnt_nxt [3];
  logic [2:0]       flip;
  logic [2:0]       press_nxt;

  logic [3:0] digit_nxt;
  logic       strobe_nxt;

  assign key_raw = {key_load_n, key_down_n, key_up_n};

  // Levels are active-low, so a flip to 0 is a press.
  always_comb begin
    flip      = '0;
    press_nxt = '0;
    for (int k = 0; k < 3; k++) begin
      cnt_nxt[k] = '0;
      flip[k]    = (key_s[k] != stable[k]) &&
                   (cnt[k] == CNT_LAST);
      if (key_s[k] != stable[k] && !flip[k])
        cnt_nxt[k] = cnt[k] + CNT_ONE;
      press_nxt[k] = flip[k] & ~key_s[k];
    end
  end

  always_comb begin
    digit_nxt  = hex_digit;
    strobe_nxt = 1'b0;
    unique case (1'b1)
      press[LD]: begin
        digit_nxt  = sw_s;
        strobe_nxt = 1'b1;
      end
      !press[LD] && press[UP] && !press[DN]: begin
        digit_nxt  = hex_digit + 4'd1;
        strobe_nxt = 1'b1;
      end
      !press[LD] && press[DN] && !press[UP]: begin
        digit_nxt  = hex_digit - 4'd1;
        strobe_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta     <= '1;
      key_s        <= '1;
      sw_meta      <= '1;
      sw_s         <= '1;
      stable       <= '1;
      press        <= '0;
      for (int k = 0; k < 3; k++)
        cnt[k] <= '0;
      hex_digit    <= '0;
      digit_strobe <= 1'b0;
    end else begin
      key_meta     <= key_raw;
      key_s        <= key_meta;
      sw_meta      <= sw;
      sw_s         <= sw_meta;
      stable       <= stable ^ flip;
      press        <= press_nxt;
      for (int k = 0; k < 3; k++)
        cnt[k] <= cnt_nxt[k];
      hex_digit    <= digit_nxt;
      digit_strobe <= strobe_nxt;
    end
  end

endmodule
